// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - request/response bundle for alu_multicycle
//
// Ports (master = requester/consumer, slave = alu_multicycle):
//   in_valid, op, a, b, out_ready         master -> slave
//   in_ready, out_valid, result, zero,
//   carry, overflow, illegal, busy        slave -> master
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, carry, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, carry, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle ops, shift-add MUL and optional restoring divider
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    alu_multicycle_if.slave: in_valid/in_ready/op/a/b request side,
//          out_valid/out_ready/result/zero/carry/overflow/illegal response side, busy
// Configuration:
//   ALU_MULTICYCLE_DIV_EN  defined: DIVU/REMU implemented (WIDTH-cycle restoring divide)
//                          undefined: DIVU/REMU are illegal like op F
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    alu_multicycle_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_AUIPC = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_BTGT  = 4'h6;
    localparam logic [3:0] OP_SLL   = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLTU  = 4'h9;
    localparam logic [3:0] OP_XOR   = 4'hA;
    localparam logic [3:0] OP_SRL   = 4'hB;
    localparam logic [3:0] OP_SRA   = 4'hC;
`ifdef ALU_MULTICYCLE_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'hD;
    localparam logic [3:0] OP_REMU  = 4'hE;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_next, start_state;
    logic [SW-1:0]    cnt;
    // acc: MUL partial product / DIV partial remainder
    // sh_a: MUL multiplicand (shifts left) / DIV dividend shifting out, quotient shifting in
    // sh_b: MUL multiplier (shifts right) / DIV divisor
    logic [WIDTH-1:0] acc, sh_a, sh_b;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, carry_q, overflow_q, illegal_q;
    logic             in_ready, accept, last_iter, is_mul;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry, sc_ovf, sc_illegal;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] mul_acc_next;

    assign in_ready  = !reset && (state == IDLE || (state == DONE && bus.out_ready));
    assign accept    = bus.in_valid && in_ready;
    assign last_iter = (cnt == SW'(WIDTH - 1));
    assign is_mul    = (bus.op == OP_MUL);
    assign shamt     = bus.b[SW-1:0];

`ifdef ALU_MULTICYCLE_DIV_EN
    logic             is_div;
    logic [3:0]       op_q;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_next, div_quot_next;

    assign is_div       = (bus.op == OP_DIVU) || (bus.op == OP_REMU);
    assign start_state  = is_mul ? MUL : (is_div ? DIV : DONE);
    assign div_shift    = {acc, sh_a[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, sh_b};
    assign div_ge       = (div_shift >= {1'b0, sh_b});
    // Remainder always stays below the divisor, so the truncation loses nothing.
    // A zero divisor makes every step succeed: quotient all ones, remainder = a.
    assign div_rem_next  = WIDTH'(div_ge ? div_diff : div_shift);
    assign div_quot_next = {sh_a[WIDTH-2:0], div_ge};
`else
    assign start_state  = is_mul ? MUL : DONE;
`endif

    assign mul_acc_next = acc + (sh_b[0] ? sh_a : '0);

    always_comb begin
        add_full   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full   = {1'b0, bus.a} - {1'b0, bus.b};
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (bus.op)
            OP_AND:   sc_result = bus.a & bus.b;
            OP_OR:    sc_result = bus.a | bus.b;
            OP_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_carry  = add_full[WIDTH];
                sc_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AUIPC: sc_result = bus.a + (bus.b << 12) - WIDTH'(4);
            OP_SUB: begin
                sc_result = sub_full[WIDTH-1:0];
                sc_carry  = sub_full[WIDTH];   // borrow: a < b unsigned
                sc_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (sub_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_BTGT:  sc_result = (bus.a - WIDTH'(4)) + bus.b;
            OP_SLL:   sc_result = bus.a << shamt;
            OP_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU:  sc_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:   sc_result = bus.a ^ bus.b;
            OP_SRL:   sc_result = bus.a >> shamt;
            OP_SRA:   sc_result = $unsigned($signed(bus.a) >>> shamt);
            OP_MUL:   ;
`ifdef ALU_MULTICYCLE_DIV_EN
            OP_DIVU, OP_REMU: ;
`endif
            default:  sc_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = start_state;
            MUL:  if (last_iter) state_next = DONE;
`ifdef ALU_MULTICYCLE_DIV_EN
            DIV:  if (last_iter) state_next = DONE;
`endif
            DONE: begin
                if (accept) begin
                    state_next = start_state;
                end else if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            acc        <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
            op_q       <= '0;
`endif
        end else if (accept) begin
            cnt  <= '0;
            acc  <= '0;
            sh_a <= bus.a;
            sh_b <= bus.b;
`ifdef ALU_MULTICYCLE_DIV_EN
            op_q <= bus.op;
`endif
            if (start_state == DONE) begin
                result_q   <= sc_result;
                zero_q     <= (sc_result == '0);
                carry_q    <= sc_carry;
                overflow_q <= sc_ovf;
                illegal_q  <= sc_illegal;
            end
        end else if (state == MUL) begin
            acc  <= mul_acc_next;
            sh_a <= sh_a << 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt + SW'(1);
            if (last_iter) begin
                result_q   <= mul_acc_next;
                zero_q     <= (mul_acc_next == '0);
                carry_q    <= 1'b0;
                overflow_q <= 1'b0;
                illegal_q  <= 1'b0;
            end
        end
`ifdef ALU_MULTICYCLE_DIV_EN
        else if (state == DIV) begin
            acc  <= div_rem_next;
            sh_a <= div_quot_next;
            cnt  <= cnt + SW'(1);
            if (last_iter) begin
                result_q   <= (op_q == OP_REMU) ? div_rem_next : div_quot_next;
                zero_q     <= (((op_q == OP_REMU) ? div_rem_next : div_quot_next) == '0);
                carry_q    <= 1'b0;
                overflow_q <= 1'b0;
                illegal_q  <= 1'b0;
            end
        end
`endif
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == MUL) || (state == DIV);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed vector bench for alu_multicycle (WIDTH=32)
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(32)) bus ();

    alu_multicycle #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
        logic        il;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int lat;
        bus.in_valid  = 1'b1;
        bus.op        = v.op;
        bus.a         = v.a;
        bus.b         = v.b;
        bus.out_ready = 1'b0;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_result"}, bus.result, v.res);
        chk({tag, "_zero"}, bus.zero, v.z);
        chk({tag, "_carry"}, bus.carry, v.c);
        chk({tag, "_overflow"}, bus.overflow, v.o);
        chk({tag, "_illegal"}, bus.illegal, v.il);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_drain"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cnt;
        int rdy_bad;
        int cyc;
        int seen;

        //            op     a             b             res           z  c  o  il lat
        vecs.push_back(vec_t'{4'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h1, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 0, 1});
        vecs.push_back(vec_t'{4'h2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1, 0, 0, 1});
        vecs.push_back(vec_t'{4'h5, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 0, 1, 0, 0, 1});
        vecs.push_back(vec_t'{4'h5, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h5, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 0, 1, 0, 1});
        vecs.push_back(vec_t'{4'h4, 32'h0000_1000, 32'h0000_0002, 32'h0000_2FFC, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h6, 32'h0000_0100, 32'h0000_0010, 32'h0000_010C, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h7, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'hA, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'hB, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'hC, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0, 0, 0, 0, 1});
        vecs.push_back(vec_t'{4'hF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1, 0, 0, 1, 1});
        vecs.push_back(vec_t'{4'h3, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 0, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'h3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'h3, 32'd12345,     32'd6789,      32'h04FE_D79D, 0, 0, 0, 0, 33});
`ifdef ALU_MULTICYCLE_DIV_EN
        vecs.push_back(vec_t'{4'hD, 32'd100,       32'd7,         32'd14,        0, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'hE, 32'd100,       32'd7,         32'd2,         0, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'hD, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'hE, 32'd5,         32'd0,         32'd5,         0, 0, 0, 0, 33});
        vecs.push_back(vec_t'{4'hE, 32'd21,        32'd7,         32'd0,         1, 0, 0, 0, 33});
`else
        vecs.push_back(vec_t'{4'hD, 32'd100,       32'd7,         32'd0,         1, 0, 0, 1, 1});
        vecs.push_back(vec_t'{4'hE, 32'd100,       32'd7,         32'd0,         1, 0, 0, 1, 1});
`endif

        bus.in_valid  = 1'b0;
        bus.op        = 4'h0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.zero, bus.carry, bus.overflow, bus.illegal}, 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", bus.in_ready, 1);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // MUL: busy and in_ready during iterations
        bus.in_valid = 1'b1; bus.op = 4'h3; bus.a = 32'hFFFF_FFFF; bus.b = 32'd3;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        busy_cnt = 0; rdy_bad = 0; cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.busy) busy_cnt++;
            if (bus.in_ready) rdy_bad++;
            tick();
            cyc++;
        end
        chk("mul_busy_cycles", busy_cnt, 32);
        chk("mul_in_ready_low", rdy_bad, 0);
        chk("mul_latency", cyc, 33);
        chk("mul_result", bus.result, 32'hFFFF_FFFD);
        chk("mul_busy_done", bus.busy, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // stall: SLL result held, a new request during stall is dropped
        bus.in_valid = 1'b1; bus.op = 4'h7; bus.a = 32'd1; bus.b = 32'h21;
        tick();
        bus.op = 4'h0; bus.a = 32'hF; bus.b = 32'hF;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_out_valid", k), bus.out_valid, 1);
            chk($sformatf("stall%0d_result", k), bus.result, 2);
            chk($sformatf("stall%0d_in_ready", k), bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("stall_no_queue", bus.out_valid, 0);

        // back-to-back AND then OR with out_ready held high
        bus.in_valid = 1'b1; bus.op = 4'h0; bus.a = 32'hFF00_FF00; bus.b = 32'h0FF0_0FF0;
        tick();
        chk("b2b_and_valid", bus.out_valid, 1);
        chk("b2b_and_result", bus.result, 32'h0F00_0F00);
        chk("b2b_in_ready", bus.in_ready, 1);
        bus.op = 4'h1;
        tick();
        chk("b2b_or_valid", bus.out_valid, 1);
        chk("b2b_or_result", bus.result, 32'hFFF0_FFF0);
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_idle", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        // reset during MUL at iteration 10
        bus.in_valid = 1'b1; bus.op = 4'h3; bus.a = 32'd7; bus.b = 32'd9;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        chk("abort_busy_before", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        chk("abort_no_result", seen, 0);
        run_op("post_abort_add", vec_t'{4'h2, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
